// File: rtl/adder_tree_pipe.sv
// Pipelined unsigned adder tree with valid/ready flow control, flush, and
// selectable wrap/saturate output. One register per tree level plus an output stage.
module adder_tree_pipe #(
    parameter int DSIZE  = 64,
    parameter int NUM_IN = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_IN*DSIZE-1:0] in_data,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic                    sat_en,
    input  logic                    flush,
    output logic [DSIZE-1:0]        sum,
    output logic                    sum_valid,
    input  logic                    sum_ready,
    output logic                    ovf
);

    localparam int LVL = $clog2(NUM_IN);
    localparam int FW  = DSIZE + LVL;

    logic             adv_s;
    logic [LVL:1]     vld_r;
    logic [LVL:1]     sat_r;
    logic [FW-1:0]    full_s;
    logic [DSIZE-1:0] sum_s;
    logic             ovf_s;
    logic [DSIZE-1:0] sum_r;
    logic             ovf_r;
    logic             sum_valid_r;

    // The whole pipeline moves as one; it stalls only when the output is occupied and not taken.
    assign adv_s    = ~sum_valid_r | sum_ready;
    assign in_ready = adv_s & ~flush;

    // Valid and saturate-mode bits travel alongside each tree level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_r <= '0;
            sat_r <= '0;
        end else if (flush) begin
            vld_r <= '0;
        end else if (adv_s) begin
            vld_r[1] <= in_valid;
            sat_r[1] <= sat_en;
            for (int s = 2; s <= LVL; s++) begin
                vld_r[s] <= vld_r[s-1];
                sat_r[s] <= sat_r[s-1];
            end
        end
    end

    for (genvar s = 1; s <= LVL; s++) begin : g_lvl
        localparam int W = DSIZE + s;
        localparam int N = NUM_IN >> s;

        logic [W-1:0] part_r [N];
        logic [W-1:0] next_s [N];
        logic         load_s;

        // Data only loads behind a valid upstream entry, so X on idle inputs never reaches sum.
        if (s == 1) begin : g_first
            assign load_s = in_ready & in_valid;
            // First level adds adjacent input operands, one bit wider than an operand.
            always_comb begin
                for (int i = 0; i < N; i++) begin
                    next_s[i] = {1'b0, in_data[(2*i)*DSIZE +: DSIZE]}
                              + {1'b0, in_data[(2*i+1)*DSIZE +: DSIZE]};
                end
            end
        end else begin : g_next
            assign load_s = adv_s & vld_r[s-1];
            // Deeper levels add adjacent partial sums from the level above.
            always_comb begin
                for (int i = 0; i < N; i++) begin
                    next_s[i] = {1'b0, g_lvl[s-1].part_r[2*i]}
                              + {1'b0, g_lvl[s-1].part_r[2*i+1]};
                end
            end
        end

        // Partial-sum registers for this level.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                for (int i = 0; i < N; i++) begin
                    part_r[i] <= '0;
                end
            end else if (load_s) begin
                for (int i = 0; i < N; i++) begin
                    part_r[i] <= next_s[i];
                end
            end
        end
    end

    assign full_s = g_lvl[LVL].part_r[0];

    // Any carry above DSIZE bits is an overflow; saturate clamps to all-ones.
    always_comb begin
        ovf_s = |full_s[FW-1:DSIZE];
        if (sat_r[LVL] && ovf_s) begin
            sum_s = '1;
        end else begin
            sum_s = full_s[DSIZE-1:0];
        end
    end

    // Output stage: holds the result stable while the consumer stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_valid_r <= 1'b0;
            sum_r       <= '0;
            ovf_r       <= 1'b0;
        end else if (flush) begin
            sum_valid_r <= 1'b0;
        end else if (adv_s) begin
            sum_valid_r <= vld_r[LVL];
            if (vld_r[LVL]) begin
                sum_r <= sum_s;
                ovf_r <= ovf_s;
            end
        end
    end

    assign sum       = sum_r;
    assign ovf       = ovf_r;
    assign sum_valid = sum_valid_r;

endmodule

// File: tb/tb_adder_tree_pipe.sv
// Directed self-checking bench for adder_tree_pipe: a 4x8-bit instance and a 16x64-bit instance.
module tb_adder_tree_pipe;

    logic clk;
    logic rst_n;

    logic [31:0] a_in_data;
    logic        a_in_valid, a_in_ready, a_sat_en, a_flush, a_sum_valid, a_sum_ready, a_ovf;
    logic [7:0]  a_sum;

    logic [1023:0] b_in_data;
    logic          b_in_valid, b_in_ready, b_sat_en, b_flush, b_sum_valid, b_sum_ready, b_ovf;
    logic [63:0]   b_sum;

    int checks;
    int errors;

    adder_tree_pipe #(.DSIZE(8), .NUM_IN(4)) dut_a (
        .clk(clk), .rst_n(rst_n), .in_data(a_in_data), .in_valid(a_in_valid),
        .in_ready(a_in_ready), .sat_en(a_sat_en), .flush(a_flush), .sum(a_sum),
        .sum_valid(a_sum_valid), .sum_ready(a_sum_ready), .ovf(a_ovf)
    );

    adder_tree_pipe #(.DSIZE(64), .NUM_IN(16)) dut_b (
        .clk(clk), .rst_n(rst_n), .in_data(b_in_data), .in_valid(b_in_valid),
        .in_ready(b_in_ready), .sat_en(b_sat_en), .flush(b_flush), .sum(b_sum),
        .sum_valid(b_sum_valid), .sum_ready(b_sum_ready), .ovf(b_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] pack4(input logic [7:0] o0, input logic [7:0] o1,
                                          input logic [7:0] o2, input logic [7:0] o3);
        return {o3, o2, o1, o0};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        a_in_data = '0; a_in_valid = 1'b0; a_sat_en = 1'b0; a_flush = 1'b0; a_sum_ready = 1'b1;
        b_in_data = '0; b_in_valid = 1'b0; b_sat_en = 1'b0; b_flush = 1'b0; b_sum_ready = 1'b1;
        repeat (3) tick();
        checks++;
        if (a_sum !== 8'd0 || a_sum_valid !== 1'b0 || a_ovf !== 1'b0) begin
            errors++;
            $display("FAIL reset_low: sum=%0d valid=%b ovf=%b, want 0/0/0", a_sum, a_sum_valid, a_ovf);
        end
        rst_n = 1'b1;
        tick();
        checks++;
        if (a_sum !== 8'd0 || a_sum_valid !== 1'b0 || a_ovf !== 1'b0 || a_in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_idle_a: sum=%0d valid=%b ovf=%b rdy=%b, want 0/0/0/1",
                     a_sum, a_sum_valid, a_ovf, a_in_ready);
        end
        checks++;
        if (b_sum !== 64'd0 || b_sum_valid !== 1'b0 || b_ovf !== 1'b0 || b_in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_idle_b: sum=%0h valid=%b ovf=%b rdy=%b, want 0/0/0/1",
                     b_sum, b_sum_valid, b_ovf, b_in_ready);
        end
    endtask

    task automatic test_wrap();
        int lat;
        a_in_data = pack4(8'd10, 8'd20, 8'd30, 8'd40);
        a_sat_en = 1'b0; a_in_valid = 1'b1; a_sum_ready = 1'b1;
        @(posedge clk);
        lat = 1;
        #1;
        a_in_valid = 1'b0;
        while (a_sum_valid !== 1'b1 && lat < 10) begin
            @(posedge clk); lat++; #1;
        end
        checks++;
        if (lat !== 3 || a_sum !== 8'd100 || a_ovf !== 1'b0) begin
            errors++;
            $display("FAIL wrap_single: lat=%0d sum=%0d ovf=%b, want 3/100/0", lat, a_sum, a_ovf);
        end
        tick();
        checks++;
        if (a_sum_valid !== 1'b0) begin
            errors++;
            $display("FAIL wrap_one_cycle: valid=%b, want 0", a_sum_valid);
        end
    endtask

    task automatic test_overflow();
        logic [7:0] exp_sum [2];
        int lat;
        exp_sum[0] = 8'd104;
        exp_sum[1] = 8'd255;
        for (int m = 0; m < 2; m++) begin
            a_in_data = pack4(8'd200, 8'd100, 8'd50, 8'd10);
            a_sat_en = (m == 1); a_in_valid = 1'b1; a_sum_ready = 1'b1;
            @(posedge clk);
            lat = 1;
            #1;
            a_in_valid = 1'b0; a_sat_en = 1'b0;
            while (a_sum_valid !== 1'b1 && lat < 10) begin
                @(posedge clk); lat++; #1;
            end
            checks++;
            if (lat !== 3 || a_sum !== exp_sum[m] || a_ovf !== 1'b1) begin
                errors++;
                $display("FAIL overflow_sat%0d: lat=%0d sum=%0d ovf=%b, want 3/%0d/1",
                         m, lat, a_sum, a_ovf, exp_sum[m]);
            end
            tick();
        end
    endtask

    task automatic test_back_to_back();
        int pushed, got, cyc;
        logic held, acc;
        logic [7:0] held_sum, k;
        pushed = 0; got = 0; cyc = 0; held = 1'b0; held_sum = 8'd0;
        while (got < 8 && cyc < 100) begin
            a_sum_ready = ((cyc % 3) == 0);
            a_in_valid = (pushed < 8);
            k = 8'(pushed + 1);
            a_in_data = pack4(k, k, k, k);
            a_sat_en = 1'b0;
            #1;
            checks++;
            if (a_in_ready !== (!a_sum_valid || a_sum_ready)) begin
                errors++;
                $display("FAIL stream_ready cyc%0d: in_ready=%b, want %b", cyc, a_in_ready,
                         (!a_sum_valid || a_sum_ready));
            end
            if (held) begin
                checks++;
                if (a_sum_valid !== 1'b1 || a_sum !== held_sum) begin
                    errors++;
                    $display("FAIL stream_hold cyc%0d: valid=%b sum=%0d, want 1/%0d",
                             cyc, a_sum_valid, a_sum, held_sum);
                end
            end
            if (a_sum_valid === 1'b1 && a_sum_ready) begin
                checks++;
                if (a_sum !== 8'(4 * (got + 1)) || a_ovf !== 1'b0) begin
                    errors++;
                    $display("FAIL stream_data #%0d: sum=%0d ovf=%b, want %0d/0",
                             got, a_sum, a_ovf, 4 * (got + 1));
                end
                got++;
            end
            acc = a_in_valid && (a_in_ready === 1'b1);
            held = (a_sum_valid === 1'b1) && !a_sum_ready;
            held_sum = a_sum;
            tick();
            if (acc) pushed++;
            cyc++;
        end
        a_in_valid = 1'b0; a_sum_ready = 1'b1;
        checks++;
        if (got !== 8) begin
            errors++;
            $display("FAIL stream_count: got=%0d, want 8", got);
        end
        repeat (4) tick();
    endtask

    task automatic test_flush();
        int seen, lat;
        logic [7:0] k;
        a_sum_ready = 1'b1; a_sat_en = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            k = 8'(i);
            a_in_data = pack4(k, k, k, k); a_in_valid = 1'b1;
            tick();
        end
        a_in_data = pack4(8'd4, 8'd4, 8'd4, 8'd4); a_flush = 1'b1;
        #1;
        checks++;
        if (a_in_ready !== 1'b0) begin
            errors++;
            $display("FAIL flush_ready: in_ready=%b, want 0", a_in_ready);
        end
        tick();
        a_flush = 1'b0; a_in_valid = 1'b0;
        seen = 0;
        for (int c = 0; c < 6; c++) begin
            if (a_sum_valid !== 1'b0) seen++;
            tick();
        end
        checks++;
        if (seen !== 0) begin
            errors++;
            $display("FAIL flush_drop: valid cycles=%0d, want 0", seen);
        end
        a_in_data = pack4(8'd1, 8'd2, 8'd3, 8'd5); a_in_valid = 1'b1;
        @(posedge clk);
        lat = 1;
        #1;
        a_in_valid = 1'b0;
        while (a_sum_valid !== 1'b1 && lat < 10) begin
            @(posedge clk); lat++; #1;
        end
        checks++;
        if (lat !== 3 || a_sum !== 8'd11) begin
            errors++;
            $display("FAIL flush_next: lat=%0d sum=%0d, want 3/11", lat, a_sum);
        end
        tick();
    endtask

    task automatic test_reset_midstream();
        int seen;
        logic [7:0] k;
        a_sum_ready = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            k = 8'(i + 4);
            a_in_data = pack4(k, k, k, k); a_in_valid = 1'b1;
            tick();
        end
        a_in_valid = 1'b0; a_sum_ready = 1'b0;
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (a_sum !== 8'd0 || a_sum_valid !== 1'b0 || a_ovf !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid: sum=%0d valid=%b ovf=%b, want 0/0/0", a_sum, a_sum_valid, a_ovf);
        end
        tick();
        rst_n = 1'b1;
        a_sum_ready = 1'b1;
        seen = 0;
        for (int c = 0; c < 6; c++) begin
            if (a_sum_valid !== 1'b0) seen++;
            tick();
        end
        checks++;
        if (seen !== 0) begin
            errors++;
            $display("FAIL rst_drop: valid cycles=%0d, want 0", seen);
        end
    endtask

    task automatic test_parametric();
        logic [63:0] exp_sum [2];
        int lat;
        exp_sum[0] = 64'hFFFF_FFFF_FFFF_FFF0;
        exp_sum[1] = 64'hFFFF_FFFF_FFFF_FFFF;
        for (int m = 0; m < 2; m++) begin
            b_in_data = '1; b_sat_en = (m == 1); b_in_valid = 1'b1; b_sum_ready = 1'b1;
            @(posedge clk);
            lat = 1;
            #1;
            b_in_valid = 1'b0; b_sat_en = 1'b0;
            while (b_sum_valid !== 1'b1 && lat < 12) begin
                @(posedge clk); lat++; #1;
            end
            checks++;
            if (lat !== 5 || b_sum !== exp_sum[m] || b_ovf !== 1'b1) begin
                errors++;
                $display("FAIL param16_sat%0d: lat=%0d sum=%0h ovf=%b, want 5/%0h/1",
                         m, lat, b_sum, b_ovf, exp_sum[m]);
            end
            tick();
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_wrap();
        test_overflow();
        test_back_to_back();
        test_flush();
        test_reset_midstream();
        test_parametric();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
